// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: shared word width and default data-memory address width.
package mem_unit_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W_DEFAULT = 8;
endpackage

// File: rtl/mem_unit_ram.sv
// mem_unit_ram: 2^ADDR_W x DATA_W synchronous RAM, read-before-write, async clear.
module mem_unit_ram
  import mem_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  // Both ports sample the pre-edge array, so a same-address load returns old data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_unit.sv
// mem_unit: data-memory stage; word loads/stores at aluresult, registered load data.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isld,
  input  logic              isst,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] aluresult,
  output logic [DATA_W-1:0] ldresult
);
  logic [ADDR_W-1:0] addr;
  assign addr = aluresult[ADDR_W-1:0];
  mem_unit_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (isst),
    .re    (isld),
    .addr  (addr),
    .wdata (op2),
    .rdata (ldresult)
  );
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: vector table with a scoreboard queue, plus reset corner sequences.
module tb_mem_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        isld = 0;
  logic        isst = 0;
  logic [15:0] op2 = '0;
  logic [15:0] aluresult = '0;
  logic [15:0] ldresult;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] sb [$];

  typedef struct {
    logic        ld;
    logic        st;
    logic [15:0] op2;
    logic [15:0] alu;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [17];

  mem_unit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .isld      (isld),
    .isst      (isst),
    .op2       (op2),
    .aluresult (aluresult),
    .ldresult  (ldresult)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: ldresult=%h expected=%h", name, act, req);
    end
  endtask

  task automatic step(input string name, input logic ld, input logic st,
                      input logic [15:0] d, input logic [15:0] a, input logic [15:0] e);
    @(negedge clk);
    isld = ld;
    isst = st;
    op2 = d;
    aluresult = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check({name, "_sb_empty"}, ldresult, 16'hxxxx);
    else check(name, ldresult, sb.pop_front());
  endtask

  initial begin
    vecs[0]  = '{1, 0, 16'h0000, 16'h0001, 16'h0000};
    vecs[1]  = '{0, 1, 16'hA5A5, 16'h0001, 16'h0000};
    vecs[2]  = '{1, 0, 16'h0000, 16'h0001, 16'hA5A5};
    vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 16'hA5A5};
    vecs[4]  = '{0, 0, 16'h0000, 16'h0000, 16'hA5A5};
    vecs[5]  = '{0, 1, 16'h5A5A, 16'h0002, 16'hA5A5};
    vecs[6]  = '{1, 0, 16'h0000, 16'h0002, 16'h5A5A};
    vecs[7]  = '{1, 0, 16'h0000, 16'h0001, 16'hA5A5};
    vecs[8]  = '{1, 1, 16'h1234, 16'h0003, 16'h0000};
    vecs[9]  = '{1, 0, 16'h0000, 16'h0003, 16'h1234};
    vecs[10] = '{0, 1, 16'hBEEF, 16'h0105, 16'h1234};
    vecs[11] = '{1, 0, 16'h0000, 16'h0005, 16'hBEEF};
    vecs[12] = '{1, 0, 16'h0000, 16'h0002, 16'h5A5A};
    vecs[13] = '{0, 1, 16'hFFFF, 16'h0002, 16'h5A5A};
    vecs[14] = '{1, 0, 16'h0000, 16'h0002, 16'hFFFF};
    vecs[15] = '{0, 1, 16'h7777, 16'h00FF, 16'hFFFF};
    vecs[16] = '{1, 0, 16'h0000, 16'hFFFF, 16'h7777};

    #1;
    check("reset_state", ldresult, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].op2, vecs[i].alu, vecs[i].exp);

    // Asynchronous reset mid-run, with a store pending across the reset edge.
    @(negedge clk);
    isld = 0;
    isst = 1;
    op2 = 16'h9999;
    aluresult = 16'h0004;
    #1;
    rst_n = 0;
    #1;
    check("async_reset_immediate", ldresult, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held", ldresult, 16'h0000);
    @(negedge clk);
    isst = 0;
    rst_n = 1;

    step("post_reset_ld_0001", 1, 0, 16'h0000, 16'h0001, 16'h0000);
    step("post_reset_st_lost", 1, 0, 16'h0000, 16'h0004, 16'h0000);
    step("post_reset_ld_00ff", 1, 0, 16'h0000, 16'h00FF, 16'h0000);
    step("post_reset_st_0004", 0, 1, 16'hC0DE, 16'h0004, 16'h0000);
    step("post_reset_ld_0104", 1, 0, 16'h0000, 16'h0104, 16'hC0DE);
    step("same_cycle_old_data", 1, 1, 16'h4321, 16'h0004, 16'hC0DE);
    step("same_cycle_new_data", 1, 0, 16'h0000, 16'h0004, 16'h4321);

    if (sb.size() != 0) check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: ldresult=%h expected=finish", ldresult);
    $fatal(1, "timeout");
  end
endmodule
